// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: widths, the canonical NOP and fetch-stage types.
package arm_pipe_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // MOV r0,r0 -- what decode sees whenever IF/ID holds no real instruction
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;

  // F_IDLE: nothing outstanding; F_WAIT: one outstanding, keep it;
  // F_DISCARD: one outstanding but made stale by a redirect, drop it
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DISCARD} fetch_state_t;

  // Prefetch entry: pc is already PC+4 of the instruction (ARM convention)
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO between instruction memory and the IF/ID register.
module fetch_fifo
  import arm_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // pop only real data; push at full is fine when the same cycle pops
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; clear wins over everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction fetch: PC, one-outstanding imem requests, prefetch FIFO, IF/ID register.
module if_stage_fetch
  import arm_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc, req_addr;
  logic          push, pop, slot_ok, room_ok, issue, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head, wentry;

  assign push    = imem_valid && (state == F_WAIT) && !branch_taken;
  assign pop     = !freeze && !branch_taken && !fifo_empty;
  // back-to-back issue is allowed in the cycle the current response lands
  assign slot_ok = (state == F_IDLE) || ((state == F_WAIT) && imem_valid);
  // keep a free slot for the new request's response: DEPTH-count+pop >= push+1
  assign room_ok = (FIFO_DEPTH + int'(pop)) >= (int'(fifo_count) + int'(push) + 1);
  assign issue   = !rst && !branch_taken && slot_ok && room_ok;

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign wentry    = '{pc: req_addr + 32'd4, instr: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (branch_taken),
    .wdata (wentry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Next fetch state: redirect turns an in-flight fetch stale
  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE:    if (issue) state_nxt = F_WAIT;
      F_WAIT: begin
        if (branch_taken)    state_nxt = imem_valid ? F_IDLE : F_DISCARD;
        else if (issue)      state_nxt = F_WAIT;
        else if (imem_valid) state_nxt = F_IDLE;
      end
      F_DISCARD: if (imem_valid) state_nxt = F_IDLE;
      default:   state_nxt = F_IDLE;
    endcase
  end

  // State, PC and the address tag of the outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= F_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (branch_taken) begin
        pc <= branch_addr;
      end else if (issue) begin
        pc       <= pc + 32'd4;
        req_addr <= pc;
      end
    end
  end

  // IF/ID register: redirect flushes, freeze holds, otherwise take FIFO head or a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (branch_taken) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (!freeze) begin
      if (!fifo_empty) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= head.pc;
        if_id_instr <= head.instr;
      end else begin
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a variable-latency instruction memory model.
module tb_if_stage_fetch;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
  );

  always #5 clk = ~clk;

  // memory contents: recognisable word per address
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // instruction memory: accepts a request on the edge imem_req is high,
  // answers with a one-cycle imem_valid pulse mem_lat cycles later
  int          mem_lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (cnt == 1) begin
      imem_valid <= 1'b1;
      imem_rdata <= memw(paddr);
    end
    if (cnt > 0) cnt <= cnt - 1;
    if (imem_req) begin
      paddr <= imem_addr;
      if (mem_lat == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= memw(imem_addr);
        cnt        <= 0;
      end else begin
        cnt <= mem_lat - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // hold reset long enough for the memory model to drain, check reset state, release
  task automatic do_reset(input int lat);
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    mem_lat = lat;
    repeat (4) tick();
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_pc",    if_id_pc, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!if_id_valid && k < 30) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, if_id_valid}, 32'd1);
  endtask

  initial begin
    // ---- sequential fetch, 1-cycle memory ----
    do_reset(1);
    chk("rel_req",  {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    tick();
    chk("e1_addr",  imem_addr, 32'h4);
    chk("e1_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    chk("e2_valid", {31'b0, if_id_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_valid", {31'b0, if_id_valid}, 32'd1);
      chk("seq_pc",    if_id_pc, 32'(4 * i + 4));
      chk("seq_instr", if_id_instr, memw(32'(4 * i)));
    end

    // ---- freeze for 3 cycles: hold IF/ID, FIFO fills, requests stop ----
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_pc",  if_id_pc, 32'hC);
      chk("frz_req", {31'b0, imem_req}, 32'd0);
    end
    freeze = 1'b0;
    #1;
    chk("unfrz_req",  {31'b0, imem_req}, 32'd1);
    chk("unfrz_addr", imem_addr, 32'h14);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("resume_pc",    if_id_pc, 32'(16 + 4 * i));
      chk("resume_instr", if_id_instr, memw(32'(12 + 4 * i)));
    end

    // ---- 3-cycle memory, redirect one cycle after request -> discard ----
    do_reset(3);
    tick();
    branch_taken = 1'b1; branch_addr = 32'h100;
    #1;
    chk("br_req_low", {31'b0, imem_req}, 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("disc_req0", {31'b0, imem_req}, 32'd0);
    tick();
    chk("disc_req1", {31'b0, imem_req}, 32'd0);
    tick();
    chk("disc_done_req",  {31'b0, imem_req}, 32'd1);
    chk("disc_done_addr", imem_addr, 32'h100);
    chk("disc_if_valid",  {31'b0, if_id_valid}, 32'd0);
    wait_valid("disc_wait");
    chk("disc_pc",    if_id_pc, 32'h104);
    chk("disc_instr", if_id_instr, memw(32'h100));

    // ---- redirect together with freeze ----
    do_reset(1);
    repeat (4) tick();
    chk("bf_pre_pc", if_id_pc, 32'h8);
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
    tick();
    branch_taken = 1'b0;
    #1;
    chk("bf_valid", {31'b0, if_id_valid}, 32'd0);
    chk("bf_instr", if_id_instr, NOP);
    chk("bf_pc",    if_id_pc, 32'h0);
    chk("bf_addr",  imem_addr, 32'h200);
    chk("bf_req",   {31'b0, imem_req}, 32'd1);
    freeze = 1'b0;
    tick();
    chk("bf_empty", {31'b0, if_id_valid}, 32'd0);
    repeat (2) tick();
    chk("bf_first_pc",    if_id_pc, 32'h204);
    chk("bf_first_instr", if_id_instr, memw(32'h200));

    // ---- redirect in the cycle the response returns ----
    do_reset(3);
    repeat (3) tick();
    branch_taken = 1'b1; branch_addr = 32'h300;
    #1;
    chk("brv_req_low", {31'b0, imem_req}, 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("brv_req",  {31'b0, imem_req}, 32'd1);
    chk("brv_addr", imem_addr, 32'h300);
    wait_valid("brv_wait");
    chk("brv_pc",    if_id_pc, 32'h304);
    chk("brv_instr", if_id_instr, memw(32'h300));

    // ---- reset while a fetch is in flight; stale response lands after release ----
    do_reset(3);
    branch_taken = 1'b1; branch_addr = 32'h500;
    tick();
    branch_taken = 1'b0;
    #1;
    chk("mid_addr", imem_addr, 32'h500);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_req",  {31'b0, imem_req}, 32'd1);
    chk("mid_rel_addr", imem_addr, 32'h0);
    wait_valid("mid_wait");
    chk("mid_pc",    if_id_pc, 32'h4);
    chk("mid_instr", if_id_instr, memw(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
